// File: rtl/fifo_rd_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ptr_ctrl
//  Description : Read-side pointer controller of a dual-clock grey-pointer
//                FIFO. Synchronises the write grey pointer into the read
//                domain, keeps the read pointer, EMPTY flag and fill level,
//                drives the memory read port and returns a registered grey
//                read pointer to the write domain.
//                Optional macro FIFO_RD_UNDERFLOW_EN enables sticky
//                pop-while-empty detection on UNDERFLOW.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ptr_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH:0]   WR_PTR_GREY,
    input  logic                  POP,
    output logic                  MEM_RE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  RD_VALID,
    output logic [ADDR_WIDTH:0]   RD_PTR_GREY,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  UNDERFLOW
);

    localparam int c_PW = ADDR_WIDTH + 1;

    logic [c_PW-1:0] r_sync [SYNC_STAGES];
    logic [c_PW-1:0] w_wr_grey_s;
    logic [c_PW-1:0] w_wr_bin;
    logic [c_PW-1:0] r_rd_bin;
    logic [c_PW-1:0] w_rd_bin_nxt;
    logic [c_PW-1:0] w_rd_grey_nxt;
    logic            w_accept;
    logic [c_PW-1:0] r_rd_grey;
    logic            r_empty;
    logic [c_PW-1:0] r_level;
    logic            r_rd_valid;

    // Synchroniser chain: the asynchronous pointer lands directly on the first flop
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= WR_PTR_GREY;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_wr_grey_s = r_sync[SYNC_STAGES-1];

    // Grey-to-binary: each binary bit is the XOR of all grey bits at or above it
    generate
        for (genvar gi = 0; gi < c_PW; gi++) begin : g_grey2bin
            assign w_wr_bin[gi] = ^w_wr_grey_s[c_PW-1:gi];
        end
    endgenerate

    // A pop is only honoured while the registered EMPTY flag is low
    assign w_accept      = POP && !r_empty;
    assign w_rd_bin_nxt  = r_rd_bin + {{ADDR_WIDTH{1'b0}}, w_accept};
    assign w_rd_grey_nxt = w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);

    // Read pointer, grey pointer, flags and level all advance together
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_bin   <= '0;
            r_rd_grey  <= '0;
            r_empty    <= 1'b1;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_bin   <= w_rd_bin_nxt;
            r_rd_grey  <= w_rd_grey_nxt;
            r_empty    <= (w_rd_grey_nxt == w_wr_grey_s);
            r_level    <= w_wr_bin - w_rd_bin_nxt;
            r_rd_valid <= w_accept;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    logic r_underflow;

    // Sticky error: any pop attempted while empty, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_underflow <= 1'b0;
        end else if (POP && r_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign UNDERFLOW = r_underflow;
`else
    assign UNDERFLOW = 1'b0;
`endif

    assign MEM_RE      = w_accept;
    assign MEM_ADDR    = r_rd_bin[ADDR_WIDTH-1:0];
    assign RD_VALID    = r_rd_valid;
    assign RD_PTR_GREY = r_rd_grey;
    assign EMPTY       = r_empty;
    assign LEVEL       = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_ptr_ctrl
//  Description : Self-checking bench for fifo_rd_ptr_ctrl. A counter-based
//                occupancy model (read/write counts, a delay line for the
//                pointer crossing) predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ptr_ctrl;

    localparam int c_AW    = 4;
    localparam int c_PW    = c_AW + 1;
    localparam int c_SS    = 2;
    localparam int c_DEPTH = 1 << c_AW;
    localparam int c_MOD   = 1 << c_PW;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [c_PW-1:0] WR_PTR_GREY = '0;
    logic            POP = 1'b0;
    logic            MEM_RE;
    logic [c_AW-1:0] MEM_ADDR;
    logic            RD_VALID;
    logic [c_PW-1:0] RD_PTR_GREY;
    logic            EMPTY;
    logic [c_PW-1:0] LEVEL;
    logic            UNDERFLOW;

    fifo_rd_ptr_ctrl #(
        .ADDR_WIDTH  (c_AW),
        .SYNC_STAGES (c_SS)
    ) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .WR_PTR_GREY (WR_PTR_GREY),
        .POP         (POP),
        .MEM_RE      (MEM_RE),
        .MEM_ADDR    (MEM_ADDR),
        .RD_VALID    (RD_VALID),
        .RD_PTR_GREY (RD_PTR_GREY),
        .EMPTY       (EMPTY),
        .LEVEL       (LEVEL),
        .UNDERFLOW   (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: entries read so far and written so far (mod 2*depth)
    int m_rd    = 0;
    int m_wr    = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    bit m_valid = 1'b0;
    bit m_under = 1'b0;
    bit m_known = 1'b0;
    int m_dly[$];

    function automatic logic [c_PW-1:0] to_gray(input int b);
        logic [c_PW-1:0] v;
        v = b[c_PW-1:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    // One read-clock cycle: drive inputs, check outputs mid-cycle, advance model at the edge
    task automatic step(input bit rst, input bit pop, input int wbin);
        bit acc;
        int ws;
        RST         = rst;
        POP         = pop;
        WR_PTR_GREY = to_gray(wbin);
        @(negedge CLK);
        acc = pop && !m_empty;
        if (m_known) begin
            check("mem_re", int'(MEM_RE), int'(acc));
            if (acc) check("mem_addr", int'(MEM_ADDR), m_rd % c_DEPTH);
            check("empty", int'(EMPTY), int'(m_empty));
            check("level", int'(LEVEL), m_level);
            check("rd_grey", int'(RD_PTR_GREY), int'(to_gray(m_rd)));
            check("rd_valid", int'(RD_VALID), int'(m_valid));
            check("underflow", int'(UNDERFLOW), int'(m_under));
        end
        @(posedge CLK);
        if (rst) begin
            m_rd    = 0;
            m_level = 0;
            m_empty = 1'b1;
            m_valid = 1'b0;
            m_under = 1'b0;
            m_dly   = {};
            for (int i = 0; i < c_SS; i++) m_dly.push_back(0);
            m_known = 1'b1;
        end else begin
            ws = m_dly[c_SS-1];
            m_dly.push_front(wbin % c_MOD);
            void'(m_dly.pop_back());
`ifdef FIFO_RD_UNDERFLOW_EN
            if (pop && m_empty) m_under = 1'b1;
`endif
            m_rd    = (m_rd + int'(acc)) % c_MOD;
            m_level = (ws - m_rd + c_MOD) % c_MOD;
            m_empty = (ws == m_rd);
            m_valid = acc;
        end
        #1;
    endtask

    int occ;
    bit do_pop;

    initial begin
        // Reset with POP held high
        m_wr = 0;
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        check("rst_empty", int'(EMPTY), 1);
        check("rst_level", int'(LEVEL), 0);
        check("rst_grey", int'(RD_PTR_GREY), 0);
        check("rst_mem_re", int'(MEM_RE), 0);

        // Write pointer jumps to 3: visible exactly three edges later
        m_wr = 3;
        step(1'b0, 1'b0, m_wr);
        step(1'b0, 1'b0, m_wr);
        check("arrive_early_level", int'(LEVEL), 0);
        check("arrive_early_empty", int'(EMPTY), 1);
        step(1'b0, 1'b0, m_wr);
        check("arrive_level", int'(LEVEL), 3);
        check("arrive_empty", int'(EMPTY), 0);

        // Drain with four pops; the fourth is ignored
        repeat (4) step(1'b0, 1'b1, m_wr);
        check("drain_empty", int'(EMPTY), 1);
        check("drain_level", int'(LEVEL), 0);
        check("drain_grey", int'(RD_PTR_GREY), 2);

        // Pop while empty
        repeat (3) step(1'b0, 1'b1, m_wr);
`ifdef FIFO_RD_UNDERFLOW_EN
        check("underflow_set", int'(UNDERFLOW), 1);
`else
        check("underflow_off", int'(UNDERFLOW), 0);
`endif
        check("underflow_grey", int'(RD_PTR_GREY), 2);

        // Pop lands on the same edge the synced write pointer moves 5 -> 6
        m_wr = 5;
        repeat (4) step(1'b0, 1'b0, m_wr);
        check("simul_pre_level", int'(LEVEL), 2);
        m_wr = 6;
        step(1'b0, 1'b0, m_wr);
        step(1'b0, 1'b0, m_wr);
        step(1'b0, 1'b1, m_wr);
        check("simul_level", int'(LEVEL), 2);

        // Fill to full occupancy one write at a time
        while (((m_wr - m_rd + c_MOD) % c_MOD) < c_DEPTH) begin
            m_wr = (m_wr + 1) % c_MOD;
            step(1'b0, 1'b0, m_wr);
        end
        repeat (3) step(1'b0, 1'b0, m_wr);
        check("full_level", int'(LEVEL), c_DEPTH);
        check("full_empty", int'(EMPTY), 0);

        // Randomised fill/drain phases, wrapping the pointers many times
        for (int i = 0; i < 800; i++) begin
            occ = (m_wr - m_rd + c_MOD) % c_MOD;
            if (((i / 40) % 2) == 0) begin
                if ($urandom_range(0, 9) < 8 && occ < c_DEPTH) m_wr = (m_wr + 1) % c_MOD;
                do_pop = ($urandom_range(0, 9) < 2);
            end else begin
                if ($urandom_range(0, 9) < 2 && occ < c_DEPTH) m_wr = (m_wr + 1) % c_MOD;
                do_pop = ($urandom_range(0, 9) < 8);
            end
            step(1'b0, do_pop, m_wr);
        end

        // Reset in mid-operation, writer reset concurrently
        m_wr = 0;
        step(1'b1, 1'b1, m_wr);
        check("midrst_empty", int'(EMPTY), 1);
        check("midrst_level", int'(LEVEL), 0);
        check("midrst_grey", int'(RD_PTR_GREY), 0);
        check("midrst_under", int'(UNDERFLOW), 0);
        repeat (3) step(1'b0, 1'b0, m_wr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
